// File: rtl/dice_round_ctrl.sv
// Round sequencer for the six-die prize evaluator: gathers six dice, presents them as one
// stable bus, captures the evaluator's prize vector after a settle time and hands it off.
module dice_round_ctrl #(
  parameter int unsigned EVAL_WAIT = 2,
  parameter int unsigned RW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          die_valid,
  input  logic [2:0]    die_value,
  output logic          die_ready,
  input  logic          abort,
  output logic [17:0]   dice_bus,
  input  logic [5:0]    prize_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [5:0]    res_prize,
  output logic          res_err,
  output logic [RW-1:0] res_round,
  output logic [RW-1:0] round_count,
  output logic [RW-1:0] win_count,
  output logic          busy
);

  typedef enum logic [1:0] {
    StLoad,
    StEval,
    StDone
  } state_e;

  localparam logic [3:0] WaitInit = 4'(EVAL_WAIT);

  state_e        state_q;
  logic [2:0]    idx_q;
  logic [2:0]    slot_q [5];
  logic [3:0]    wait_q;
  logic          err_q;
  logic [17:0]   dice_bus_q;
  logic          res_valid_q;
  logic [5:0]    res_prize_q;
  logic          res_err_q;
  logic [RW-1:0] res_round_q;
  logic [RW-1:0] round_q;
  logic [RW-1:0] win_q;

  logic die_illegal;
  assign die_illegal = (die_value == 3'd0) || (die_value == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      for (int i = 0; i < 5; i++) slot_q[i] <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      dice_bus_q  <= '0;
      res_valid_q <= 1'b0;
      res_prize_q <= '0;
      res_err_q   <= 1'b0;
      res_round_q <= '0;
      round_q     <= '0;
      win_q       <= '0;
    end else begin
      case (state_q)
        StLoad: begin
          if (abort) begin
            idx_q <= '0;
            err_q <= 1'b0;
          end else if (die_valid) begin
            if (die_illegal) err_q <= 1'b1;
            if (idx_q == 3'd5) begin
              // The sixth die goes straight onto the bus so the evaluator sees a whole round.
              dice_bus_q <= {slot_q[0], slot_q[1], slot_q[2], slot_q[3], slot_q[4], die_value};
              idx_q      <= '0;
              wait_q     <= WaitInit;
              state_q    <= StEval;
            end else begin
              for (int i = 0; i < 5; i++) begin
                if (idx_q == 3'(i)) slot_q[i] <= die_value;
              end
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        StEval: begin
          if (abort) begin
            err_q   <= 1'b0;
            state_q <= StLoad;
          end else if (wait_q == 4'd1) begin
            wait_q      <= '0;
            res_prize_q <= err_q ? 6'd0 : prize_in;
            res_err_q   <= err_q;
            res_round_q <= round_q;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StDone: begin
          // res_valid is always high here, so res_ready alone completes the handshake.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            round_q     <= round_q + RW'(1);
            if (|res_prize_q) win_q <= win_q + RW'(1);
            err_q       <= 1'b0;
            state_q     <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign die_ready   = (state_q == StLoad) && !abort;
  assign busy        = (state_q != StLoad) || (idx_q != 3'd0);
  assign dice_bus    = dice_bus_q;
  assign res_valid   = res_valid_q;
  assign res_prize   = res_prize_q;
  assign res_err     = res_err_q;
  assign res_round   = res_round_q;
  assign round_count = round_q;
  assign win_count   = win_q;

endmodule

// File: tb/tb_dice_round_ctrl.sv
// Scoreboard bench for dice_round_ctrl: a driver issues rounds and queues expected results,
// a monitor compares every presented result; a second instance runs with 2-bit counters.
module tb_dice_round_ctrl;

  localparam int unsigned EW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        die_valid = 1'b0;
  logic [2:0]  die_value = 3'd0;
  logic        abort = 1'b0;
  logic [5:0]  prize_in = 6'd0;
  logic        res_ready = 1'b0;

  logic        die_ready, res_valid, res_err, busy;
  logic [17:0] dice_bus;
  logic [5:0]  res_prize;
  logic [7:0]  res_round, round_count, win_count;

  logic        die_ready_b, res_valid_b, res_err_b, busy_b;
  logic [17:0] dice_bus_b;
  logic [5:0]  res_prize_b;
  logic [1:0]  res_round_b, round_count_b, win_count_b;

  dice_round_ctrl #(.EVAL_WAIT(EW), .RW(8)) dut (
    .clk(clk), .rst_n(rst_n), .die_valid(die_valid), .die_value(die_value),
    .die_ready(die_ready), .abort(abort), .dice_bus(dice_bus), .prize_in(prize_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_prize(res_prize), .res_err(res_err),
    .res_round(res_round), .round_count(round_count), .win_count(win_count), .busy(busy)
  );

  dice_round_ctrl #(.EVAL_WAIT(EW), .RW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .die_valid(die_valid), .die_value(die_value),
    .die_ready(die_ready_b), .abort(abort), .dice_bus(dice_bus_b), .prize_in(prize_in),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_prize(res_prize_b),
    .res_err(res_err_b), .res_round(res_round_b), .round_count(round_count_b),
    .win_count(win_count_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] prize;
    logic       err;
    logic [7:0] rnd;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] issued = 8'd0;
  bit         scramble = 1'b0;
  int         hold_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic give_up(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
    finish_run();
  endtask

  function automatic logic [2:0] rand_die(input bit allow_bad);
    if (allow_bad && $urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
    return 3'($urandom_range(1, 6));
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      die_valid = 1'b0;
      if (scramble) prize_in = 6'($urandom);
      @(negedge clk);
    end
  endtask

  // Holds die_valid until accepted; returns on the negedge after the accepting edge.
  task automatic offer(input logic [2:0] v);
    int n = 0;
    die_valid = 1'b1;
    die_value = v;
    #1;
    while (!die_ready && n < 400) begin
      if (scramble) prize_in = 6'($urandom);
      @(negedge clk);
      #1;
      n++;
    end
    if (!die_ready) give_up("die_accept_timeout");
    @(posedge clk);
    @(negedge clk);
    die_valid = 1'b0;
  endtask

  task automatic run_round(input logic [2:0] d [6], input logic [5:0] p, input int gap,
                           input bit ab_eval, input int hold);
    logic        err = 1'b0;
    logic [17:0] bus = '0;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      if (d[i] == 3'd0 || d[i] == 3'd7) err = 1'b1;
      bus = {bus[14:0], d[i]};
    end
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(0, gap));
      if (i == 5) begin
        scramble    = 1'b0;
        prize_in    = p;
        hold_cycles = hold;
      end
      offer(d[i]);
      if (i == 0) begin
        chk("busy_mid_round", busy, 1);
        chk("busy_mid_round_b", busy_b, 1);
      end
    end
    chk("dice_bus", dice_bus, bus);
    chk("dice_bus_b", dice_bus_b, bus);
    chk("die_ready_in_eval", die_ready, 0);
    if (ab_eval) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("die_ready_after_eval_abort", die_ready, 1);
      chk("busy_after_eval_abort", busy, 0);
      scramble = 1'b1;
    end else begin
      e.prize = err ? 6'd0 : p;
      e.err   = err;
      e.rnd   = issued;
      sb.push_back(e);
      issued++;
      repeat (EW - 1) @(negedge clk);
      chk("res_valid_early", res_valid, 0);
      @(negedge clk);
      chk("res_valid_latency", res_valid, 1);
      scramble = 1'b1;
    end
  endtask

  task automatic abort_load(input int k);
    for (int i = 0; i < k; i++) offer(rand_die(1'b1));
    die_valid = 1'b1;
    die_value = rand_die(1'b0);
    abort     = 1'b1;
    #1;
    chk("die_ready_during_abort", die_ready, 0);
    @(negedge clk);
    abort     = 1'b0;
    die_valid = 1'b0;
    #1;
    chk("busy_after_load_abort", busy, 0);
  endtask

  task automatic monitor();
    logic [7:0] er = 8'd0;
    logic [7:0] ew = 8'd0;
    bit         drop = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        er = 8'd0;
        ew = 8'd0;
        drop = 1'b0;
        sb.delete();
        continue;
      end
      chk("round_count", round_count, er);
      chk("win_count", win_count, ew);
      chk("round_count_b", round_count_b, er[1:0]);
      chk("win_count_b", win_count_b, ew[1:0]);
      if (drop) begin
        chk("res_valid_drop", res_valid, 0);
        drop = 1'b0;
      end
      if (res_valid_b && sb.size() > 0) begin
        chk("res_prize_b", res_prize_b, sb[0].prize);
        chk("res_err_b", res_err_b, sb[0].err);
        chk("res_round_b", res_round_b, sb[0].rnd[1:0]);
        chk("die_ready_b_pending", die_ready_b, 0);
      end
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("res_valid_unexpected", res_valid, 0);
        end else begin
          chk("res_prize", res_prize, sb[0].prize);
          chk("res_err", res_err, sb[0].err);
          chk("res_round", res_round, sb[0].rnd);
          chk("die_ready_pending", die_ready, 0);
          if (res_ready) begin
            e = sb.pop_front();
            er++;
            if (|e.prize) ew++;
            drop = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic consumer();
    int age = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !res_valid) age = 0;
      else age++;
      if (hold_cycles > 0 && age > 0) res_ready = (age > hold_cycles);
      else res_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    logic [2:0] d [6];
    int         n;
    fork
      monitor();
      consumer();
    join_none

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_die_ready", die_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_dice_bus", dice_bus, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_prize", res_prize, 0);
    chk("reset_res_err", res_err, 0);
    chk("reset_res_round", res_round, 0);
    @(negedge clk);

    d = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd6};
    run_round(d, 6'b100000, 0, 1'b0, 0);
    d = '{3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0};
    run_round(d, 6'b000010, 0, 1'b0, 0);
    abort_load(3);
    d = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    run_round(d, 6'b001100, 0, 1'b0, 0);
    d = '{3'd6, 3'd5, 3'd6, 3'd5, 3'd6, 3'd5};
    run_round(d, 6'b010001, 1, 1'b0, 20);
    d = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1};
    run_round(d, 6'b111111, 0, 1'b1, 0);
    run_round(d, 6'b000100, 0, 1'b0, 0);

    // Enough prize-free rounds to push the 2-bit counters through a wrap.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) d[i] = rand_die(1'b0);
      run_round(d, 6'd0, 1, 1'b0, 0);
    end

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 5) == 0) abort_load($urandom_range(1, 5));
      for (int i = 0; i < 6; i++) d[i] = rand_die(1'b1);
      run_round(d, 6'($urandom), 3, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0) ? 5 : 0);
    end

    // Asynchronous reset in the middle of loading a round.
    for (int i = 0; i < 3; i++) offer(rand_die(1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dice_bus", dice_bus, 0);
    chk("async_rst_res_valid", res_valid, 0);
    chk("async_rst_res_prize", res_prize, 0);
    chk("async_rst_res_err", res_err, 0);
    chk("async_rst_res_round", res_round, 0);
    chk("async_rst_round_count", round_count, 0);
    chk("async_rst_win_count", win_count, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_dice_bus_b", dice_bus_b, 0);
    chk("async_rst_round_count_b", round_count_b, 0);
    issued = 8'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_die_ready", die_ready, 1);
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) d[i] = rand_die(1'b0);
      run_round(d, 6'($urandom_range(1, 63)), 2, 1'b0, 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    finish_run();
  end

endmodule
